// File: rtl/riscv_v_pkg.sv
// Shared RISC-V vector definitions: major opcodes and the dispatch queue entry layout.
package riscv_v_pkg;

   localparam int unsigned V_XLEN = 32;

   localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
   localparam logic [6:0] OPC_VSTORE = 7'b0100111;
   localparam logic [6:0] OPC_OPV    = 7'b1010111;

   typedef struct packed {
      logic [V_XLEN-1:0] instr;
      logic [V_XLEN-1:0] rs1;
      logic [V_XLEN-1:0] rs2;
   } v_dispatch_entry_t;

endpackage

// File: rtl/v_dispatch_opc_cnt.sv
// Up/down occupancy counter for one opcode class held in the dispatch queue.
module v_dispatch_opc_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (flush_i) begin
         cnt_q <= '0;
      end else if (inc_i && !dec_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/v_dispatch_queue.sv
// FIFO decoupling the scalar vector-issue port from the vector scheduler, with queued load/store tracking.
module v_dispatch_queue
   import riscv_v_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush_i,
   input  logic                       s_valid_i,
   input  logic [DATA_W-1:0]          s_instr_i,
   input  logic [DATA_W-1:0]          s_rs1_i,
   input  logic [DATA_W-1:0]          s_rs2_i,
   output logic                       s_full_o,
   output logic [DATA_W-1:0]          vector_instr_o,
   output logic [DATA_W-1:0]          rs1_o,
   output logic [DATA_W-1:0]          rs2_o,
   input  logic                       vector_stall_i,
   output logic                       all_v_loads_queued_o,
   output logic                       all_v_stores_queued_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_err_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int ENT_W = 3 * DATA_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;
   logic             empty, push, pop;
   logic [ENT_W-1:0] head;
   logic [6:0]       push_opc, head_opc;
   logic [CNT_W-1:0] ld_cnt, st_cnt;

   assign empty    = (count_q == '0);
   assign s_full_o = (count_q == FULL_CNT);
   // Flush wins over both ports; a full queue never accepts, even if it pops this cycle.
   assign push     = s_valid_i & ~s_full_o & ~flush_i;
   assign pop      = ~empty & ~vector_stall_i & ~flush_i;

   assign head     = mem[rd_ptr_q];
   assign push_opc = s_instr_i[6:0];
   assign head_opc = head[2*DATA_W +: 7];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {s_instr_i, s_rs1_i, s_rs2_i};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
   end

   // Sticky until reset; flush deliberately leaves it set so software can still see the error.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                      ovf_q <= 1'b0;
      else if (s_valid_i && s_full_o) ovf_q <= 1'b1;
   end

   v_dispatch_opc_cnt #(.CNT_W(CNT_W)) u_ld_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (flush_i),
      .inc_i   (push && (push_opc == OPC_VLOAD)),
      .dec_i   (pop && (head_opc == OPC_VLOAD)),
      .cnt_o   (ld_cnt),
      .zero_o  (all_v_loads_queued_o)
   );

   v_dispatch_opc_cnt #(.CNT_W(CNT_W)) u_st_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (flush_i),
      .inc_i   (push && (push_opc == OPC_VSTORE)),
      .dec_i   (pop && (head_opc == OPC_VSTORE)),
      .cnt_o   (st_cnt),
      .zero_o  (all_v_stores_queued_o)
   );

   // The vector core has no valid input, so an empty queue must present all-zero fields.
   assign vector_instr_o = empty ? '0 : head[2*DATA_W +: DATA_W];
   assign rs1_o          = empty ? '0 : head[DATA_W +: DATA_W];
   assign rs2_o          = empty ? '0 : head[0 +: DATA_W];
   assign count_o        = count_q;
   assign overflow_err_o = ovf_q;

   logic unused_ok;
   assign unused_ok = ^{ld_cnt, st_cnt};

endmodule
